// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: one pipeline-stage register with a single skid entry.
// The main register drives the outputs; the skid register absorbs the one
// item that upstream may send in the cycle that downstream stalls, so that
// readyOut can be a pure function of registered state.
module pipeline_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              validIn,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [CTRL_W-1:0] ctrlIn,
   output logic              readyOut,
   output logic              validOut,
   output logic [DATA_W-1:0] dataOut,
   output logic [CTRL_W-1:0] ctrlOut,
   input  logic              readyIn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stallCount
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Next-state and storage updates; flush overrides every handshake event
   // but leaves payload storage untouched.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (validIn) begin
                  main_data_d = dataIn;
                  main_ctrl_d = ctrlIn;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (validIn && readyIn) begin
                  main_data_d = dataIn;
                  main_ctrl_d = ctrlIn;
               end else if (validIn) begin
                  skid_data_d = dataIn;
                  skid_ctrl_d = ctrlIn;
                  state_d     = FULL;
               end else if (readyIn) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (readyIn) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Stall counter counts every edge where downstream refuses a valid entry,
   // independent of flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q != EMPTY) && !readyIn) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   // State, payload and counter registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign readyOut   = (state_q != FULL);
   assign validOut   = (state_q != EMPTY);
   assign dataOut    = main_data_q;
   assign ctrlOut    = validOut ? main_ctrl_q : '0;
   assign occupancy  = state_q;
   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg: accepted inputs are queued as
// expected outputs; a monitor pops and compares on each downstream transfer.
module tb_pipeline_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              flush = 1'b0;
   logic              validIn = 1'b0;
   logic [DATA_W-1:0] dataIn = '0;
   logic [CTRL_W-1:0] ctrlIn = '0;
   logic              readyOut;
   logic              validOut;
   logic [DATA_W-1:0] dataOut;
   logic [CTRL_W-1:0] ctrlOut;
   logic              readyIn = 1'b0;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stallCount;

   pipeline_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .validIn(validIn), .dataIn(dataIn), .ctrlIn(ctrlIn), .readyOut(readyOut),
      .validOut(validOut), .dataOut(dataOut), .ctrlOut(ctrlOut), .readyIn(readyIn),
      .occupancy(occupancy), .stallCount(stallCount)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;
   int n_pop = 0;
   logic [DATA_W+CTRL_W-1:0] exp_q[$];
   logic [DATA_W+CTRL_W-1:0] mon_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic r, input logic f);
      validIn = v; dataIn = d; ctrlIn = c; readyIn = r; flush = f;
      if (f) exp_q.delete();
      else if (v && readyOut) begin
         exp_q.push_back({d, c});
         n_acc++;
      end
      @(posedge clk); #1;
   endtask

   // Monitor: compare each downstream transfer against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && !flush) begin
            if (validOut && readyIn) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL out_unexpected: got data 0x%0h ctrl 0x%0h, expected no output", dataOut, ctrlOut);
               end else begin
                  mon_e = exp_q.pop_front();
                  n_pop++;
                  chk("out_data_ctrl", 64'({dataOut, ctrlOut}), 64'(mon_e));
               end
            end else if (!validOut) begin
               chk("ctrl_mask_idle", 64'(ctrlOut), 64'(0));
            end
         end
      end
   end

   initial begin
      int sv[5];
      int acc0, pop0, guard;
      sv = '{1, 2, 3, 3, 3};

      // Reset state
      #2;
      chk("rst_validOut", 64'(validOut), 64'(0));
      chk("rst_readyOut", 64'(readyOut), 64'(1));
      chk("rst_dataOut", 64'(dataOut), 64'(0));
      chk("rst_ctrlOut", 64'(ctrlOut), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_stall", 64'(stallCount), 64'(0));
      #10 reset = 1'b1;
      @(posedge clk); #1;

      // Pass-through
      cyc(1'b1, 32'h4, 8'h15, 1'b1, 1'b0);
      chk("pt_validOut", 64'(validOut), 64'(1));
      chk("pt_dataOut", 64'(dataOut), 64'h4);
      chk("pt_ctrlOut", 64'(ctrlOut), 64'h15);
      chk("pt_occupancy", 64'(occupancy), 64'(1));

      // Back-to-back streaming at full rate
      cyc(1'b1, 32'h100, 8'h21, 1'b1, 1'b0);
      chk("burst0_data", 64'(dataOut), 64'h100);
      cyc(1'b1, 32'h104, 8'h22, 1'b1, 1'b0);
      chk("burst1_data", 64'(dataOut), 64'h104);
      chk("burst1_ready", 64'(readyOut), 64'(1));
      cyc(1'b1, 32'h108, 8'h23, 1'b1, 1'b0);
      chk("burst2_occ", 64'(occupancy), 64'(1));
      cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      chk("drain_occ", 64'(occupancy), 64'(0));
      chk("drain_valid", 64'(validOut), 64'(0));

      // Back-pressure with skid fill; third push must be refused
      cyc(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
      chk("bp_occ1", 64'(occupancy), 64'(1));
      cyc(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
      chk("bp_occ2", 64'(occupancy), 64'(2));
      chk("bp_readyOut", 64'(readyOut), 64'(0));
      chk("bp_dataOut", 64'(dataOut), 64'hA);
      cyc(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0);
      chk("bp_full_hold_occ", 64'(occupancy), 64'(2));
      chk("bp_full_hold_data", 64'(dataOut), 64'hA);
      cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      chk("bp_unskid_occ", 64'(occupancy), 64'(1));
      chk("bp_unskid_data", 64'(dataOut), 64'hB);
      cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      chk("bp_empty_occ", 64'(occupancy), 64'(0));

      // Async reset between edges while FULL
      cyc(1'b1, 32'h11, 8'h11, 1'b0, 1'b0);
      cyc(1'b1, 32'h22, 8'h22, 1'b0, 1'b0);
      chk("ar_pre_occ", 64'(occupancy), 64'(2));
      #2;
      reset = 1'b0; validIn = 1'b0;
      exp_q.delete();
      #1;
      chk("ar_validOut", 64'(validOut), 64'(0));
      chk("ar_readyOut", 64'(readyOut), 64'(1));
      chk("ar_dataOut", 64'(dataOut), 64'(0));
      chk("ar_ctrlOut", 64'(ctrlOut), 64'(0));
      chk("ar_occupancy", 64'(occupancy), 64'(0));
      chk("ar_stall", 64'(stallCount), 64'(0));
      #2 reset = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, 32'h1, 8'h01, 1'b0, 1'b0);
      chk("ar_post_valid", 64'(validOut), 64'(1));
      chk("ar_post_data", 64'(dataOut), 64'h1);
      chk("ar_post_stall", 64'(stallCount), 64'(0));

      // Saturating stall counter
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
         chk($sformatf("stall_%0d", i), 64'(stallCount), 64'(sv[i]));
      end

      // Flush from FULL with a same-cycle push
      cyc(1'b1, 32'h33, 8'h33, 1'b0, 1'b0);
      chk("fl_pre_occ", 64'(occupancy), 64'(2));
      cyc(1'b1, 32'hD, 8'h0D, 1'b0, 1'b1);
      chk("fl_validOut", 64'(validOut), 64'(0));
      chk("fl_ctrlOut", 64'(ctrlOut), 64'(0));
      chk("fl_occupancy", 64'(occupancy), 64'(0));
      chk("fl_readyOut", 64'(readyOut), 64'(1));
      chk("fl_stall_kept", 64'(stallCount), 64'(3));
      chk("fl_payload_kept", 64'(dataOut), 64'h1);
      cyc(1'b1, 32'hE, 8'h0E, 1'b1, 1'b1);
      chk("fl_empty_push_dropped", 64'(occupancy), 64'(0));
      cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

      // Random streaming
      acc0 = n_acc; pop0 = n_pop; guard = 0;
      while ((n_acc - acc0) < 100 && guard < 2000) begin
         cyc(1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         guard++;
      end
      for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      chk("stream_accepted", 64'(n_acc - acc0), 64'(100));
      chk("stream_popped", 64'(n_pop - pop0), 64'(100));
      chk("stream_queue_left", 64'(exp_q.size()), 64'(0));
      chk("stream_end_occ", 64'(occupancy), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
